// File: rtl/lmem_circ_reader.sv
// lmem_circ_reader: cyclic-shift read sequencer for one L-memory column, streaming words through a 2-entry skid buffer
module lmem_circ_reader #(
  parameter int Z = 511,
  parameter int W = 6,
  parameter int COLADDR_BITS = 9
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COLADDR_BITS-1:0] shift,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [COLADDR_BITS-1:0] RA,
  output logic                    rd_in,
  input  logic [W-1:0]            DOUT,
  output logic [W-1:0]            o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last
);
  localparam int CB = COLADDR_BITS;
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2;
  localparam logic [CB:0] ZC = (CB+1)'(Z);
  localparam logic [CB-1:0] ZM1 = CB'(Z-1);
  logic [1:0] st, cnt, occ;
  logic [CB:0] ic, oc;
  logic [W-1:0] b1;
  logic pop, accept, issue;
  // occ counts skid entries plus the read landing this edge, minus the word leaving
  always_comb begin
    o_valid = cnt != 2'd0;
    pop = o_valid & i_ready;
    occ = cnt + {1'b0, rd_in} - {1'b0, pop};
    accept = st == IDLE && start && {1'b0, shift} < ZC;
    issue = st == READ && ic < ZC && occ < 2'd2;
    o_last = o_valid && oc == ZC - 1'b1;
  end
  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      ic <= '0;
      oc <= '0;
      o_data <= '0;
      b1 <= '0;
      RA <= '0;
      rd_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_in <= accept | issue;
      done <= 1'b0;
      err <= st == IDLE && start && {1'b0, shift} >= ZC;
      cnt <= occ;
      if (accept) begin
        RA <= shift;
        ic <= 1;
        oc <= '0;
        st <= READ;
        busy <= 1'b1;
      end
      if (issue) begin
        RA <= RA == ZM1 ? '0 : RA + 1'b1;
        ic <= ic + 1'b1;
      end
      if (st == READ && ic == ZC) st <= DRAIN;
      if (pop) oc <= oc + 1'b1;
      if (pop && o_last) begin
        st <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end
      o_data <= pop ? (cnt == 2'd2 ? b1 : (rd_in ? DOUT : o_data))
                    : (cnt == 2'd0 && rd_in ? DOUT : o_data);
      if (rd_in && occ == 2'd2) b1 <= DOUT;
    end
  end
endmodule

// File: doc/lmem_circ_reader.md
Name: lmem_circ_reader

Overview:
- Read-side sequencer for the per-column L-memory (simple dual-port RAM, Z entries of W bits, negedge-registered read data).
- On each start it walks all Z locations in cyclic-shift order: (shift + k) mod Z, for k = 0..Z-1.
- Streams the words out over a valid/ready interface to the check-node datapath; this is the circulant-permuted read of one block column.
- Absorbs the one-cycle RAM read latency and downstream backpressure with a 2-entry skid buffer.

Parameters:
- Z, 511, circulant size (number of RAM locations walked per pass).
- W, 6, data word width.
- COLADDR_BITS, 9, address width; must satisfy 2^COLADDR_BITS >= Z.

Ports:
- memclk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- shift  input  COLADDR_BITS  cyclic shift, sampled with start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the pass completes.
- err  output  1  one-cycle pulse when a start is rejected because shift >= Z.
- RA  output  COLADDR_BITS  RAM read address.
- rd_in  output  1  RAM read enable.
- DOUT  input  W  RAM read data; valid on the posedge after the one where RA/rd_in were driven.
- o_data  output  W  streamed word.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_last  output  1  qualifies the final word (k = Z-1) of the pass.

Behaviour:
- Reset: rst high clears asynchronously: busy=0, done=0, err=0, rd_in=0, RA=0, o_valid=0, o_data=0, o_last=0, skid buffer empty, FSM to IDLE. Reset mid-pass abandons the pass; no done is generated; in-flight RAM data is discarded.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 and shift<Z: load rd_addr=shift, issue count=0, go to READ, busy=1 from the next cycle.
  - start=1 and shift>=Z: err=1 for one cycle, remain in IDLE.
- READ:
  - Issue a read (rd_in=1, RA=rd_addr) only when occupancy is below 2. Occupancy = skid entries + reads in flight, counting the word leaving this cycle when o_valid and i_ready are both high.
  - On each issue: rd_addr = (rd_addr == Z-1) ? 0 : rd_addr+1, and issue count increments.
  - Wrap is by compare, never by modulo arithmetic.
  - After Z issues, go to DRAIN.
  - rd_in=0 whenever no read is issued; RA then holds its last value.
- Data capture:
  - DOUT is captured into the skid buffer on the posedge after the issuing cycle, only for reads actually issued. DOUT is ignored otherwise, including the zero value the RAM returns when rd_in=0.
  - Buffer order is FIFO; o_data/o_valid present the head entry.
  - o_data is stable while o_valid=1 and i_ready=0.
- o_last=1 exactly with the word whose index k=Z-1, i.e. address (shift+Z-1) mod Z.
- DRAIN: when the o_last word is accepted, go to IDLE. done=1 in the following cycle; busy=0 in that same cycle.
- start while busy is ignored; no err is raised.
- Throughput: with i_ready held high, one word per cycle. The first o_valid appears 2 cycles after the start cycle. A pass occupies Z+2 cycles from start to done.
- The block never writes the RAM; write-side signals are owned elsewhere. RAM content is assumed static during a pass.

Test Plan:
- Z=7, RAM preloaded mem[i]=i+10, start with shift=3, i_ready=1 -> o_data sequence 13,14,15,16,10,11,12; o_last only on 12; done 1 cycle after 12 is accepted; RA wraps 6->0.
- Same setup with shift=0 and shift=6 -> sequences 10..16 and 16,10,11,...,15; no address ever reaches 7.
- Backpressure: i_ready toggled 1,0,0,1,0,1... -> no word lost or duplicated; o_data held stable while stalled; rd_in never asserted when occupancy is 2; output matches the no-stall sequence.
- start with shift=7 (Z=7) -> err pulse, busy stays 0, rd_in never asserted; a second start during an active pass -> ignored, current pass unaffected.
- rst asserted asynchronously mid-pass (after 3 words) -> all outputs 0 immediately, no done; a subsequent start with shift=2 yields a clean full 7-word pass.
- Default Z=511, shift=510, i_ready=1 -> first word is mem[510], second is mem[0], 511 words total, done at cycle start+513.
